imagine_host_adapter: RTL

- Host-side counterpart of the IMAGine core interface. It drives the core's FIFO-in port (instruction, instructionValid, instructionNext) from a buffered host instruction stream.
- It drains the core's FIFO-out port (dataout, dataAttrib, dataoutValid) into a buffered host result stream.
- It services end-of-vector signalling: detects eovInterrupt, reports the vector length, and pulses clearEOV.
- It sits between a host bus/DMA shim and the IMAGine core, standing in for the external FIFOs.

---
 rtl/imagine_host_pkg.sv | 22 ++
 rtl/imagine_sync_fifo.sv | 55 +++++
 rtl/imagine_host_adapter.sv | 116 +++++++++++
 3 files changed

// File: rtl/imagine_host_pkg.sv
// Shared types and default widths for the IMAGine host adapter.
package imagine_host_pkg;

  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ATTRIB_W = 2;
  localparam int DEF_LEN_W    = 16;

  // End-of-vector handshake with the core.
  typedef enum logic [1:0] {
    ARMED = 2'd0,
    CLEAR = 2'd1,
    WAIT  = 2'd2
  } eov_state_t;

  // One result word as presented to the host, attribute bits on top.
  typedef struct packed {
    logic [DEF_ATTRIB_W-1:0] attrib;
    logic [DEF_DATA_W-1:0]   data;
  } rword_t;

endpackage

// File: rtl/imagine_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; pointers wrap naturally.
module imagine_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; validity comes from the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imagine_host_adapter.sv
// Host-side adapter for the IMAGine core: instruction feed, result drain, EOV service.
module imagine_host_adapter
  import imagine_host_pkg::*;
#(
  parameter int INSTR_WIDTH  = DEF_INSTR_W,
  parameter int DATA_WIDTH   = DEF_DATA_W,
  parameter int ATTRIB_WIDTH = DEF_ATTRIB_W,
  parameter int IFIFO_DEPTH  = 8,
  parameter int RFIFO_DEPTH  = 16,
  parameter int LEN_WIDTH    = DEF_LEN_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INSTR_WIDTH-1:0]         host_instr,
  input  logic                           host_instr_valid,
  output logic                           host_instr_ready,
  output logic [INSTR_WIDTH-1:0]         instruction,
  output logic                           instructionValid,
  input  logic                           instructionNext,
  input  logic [DATA_WIDTH-1:0]          dataout,
  input  logic [ATTRIB_WIDTH-1:0]        dataAttrib,
  input  logic                           dataoutValid,
  input  logic                           eovInterrupt,
  output logic                           clearEOV,
  output logic [ATTRIB_WIDTH+DATA_WIDTH-1:0] host_data,
  output logic                           host_data_valid,
  input  logic                           host_data_ready,
  output logic                           vec_done,
  output logic [LEN_WIDTH-1:0]           vec_len,
  output logic                           overflow,
  input  logic                           clear_overflow
);

  localparam int RW = ATTRIB_WIDTH + DATA_WIDTH;

  logic                        ifull, iempty, ipush, ipop;
  logic                        rfull, rempty, rpush, rpop, drop;
  logic [$clog2(IFIFO_DEPTH):0] icount;
  logic [$clog2(RFIFO_DEPTH):0] rcount;
  logic                        unused_counts;
  logic [LEN_WIDTH-1:0]        word_cnt;
  eov_state_t                  state, state_next;
  logic                        eov_hit;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  assign host_instr_ready = !ifull;
  assign instructionValid = !iempty;
  assign ipush            = host_instr_valid && !ifull;
  assign ipop             = instructionValid && instructionNext;

  assign host_data_valid  = !rempty;
  assign rpop             = host_data_valid && host_data_ready;
  assign rpush            = dataoutValid && (!rfull || rpop);
  assign drop             = dataoutValid && rfull && !rpop;

  assign unused_counts    = ^{icount, rcount};

  imagine_sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(IFIFO_DEPTH)) u_ififo (
    .clk(clk), .rst(rst), .push(ipush), .pop(ipop), .din(host_instr),
    .dout(instruction), .full(ifull), .empty(iempty), .count(icount)
  );

  imagine_sync_fifo #(.WIDTH(RW), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk(clk), .rst(rst), .push(rpush), .pop(rpop), .din({dataAttrib, dataout}),
    .dout(host_data), .full(rfull), .empty(rempty), .count(rcount)
  );

  // EOV state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARMED;
    else     state <= state_next;
  end

  // EOV next state; WAIT holds until the core drops its level so one EOV counts once.
  always_comb begin
    state_next = state;
    eov_hit    = 1'b0;
    unique case (state)
      ARMED: if (eovInterrupt) begin
        state_next = CLEAR;
        eov_hit    = 1'b1;
      end
      CLEAR:   state_next = WAIT;
      WAIT:    if (!eovInterrupt) state_next = ARMED;
      default: state_next = ARMED;
    endcase
  end

  // Registered status: word counter, vector completion, clear pulse, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      vec_len  <= '0;
      vec_done <= 1'b0;
      clearEOV <= 1'b0;
      overflow <= 1'b0;
    end else begin
      clearEOV <= (state_next == CLEAR);
      vec_done <= eov_hit;
      if (eov_hit) begin
        vec_len  <= sat_inc(word_cnt, dataoutValid);
        word_cnt <= '0;
      end else begin
        word_cnt <= sat_inc(word_cnt, dataoutValid);
      end
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
